// File: rtl/ofdm_preamble_inserter_pkg.sv
// Shared definitions for the OFDM preamble inserter: FSM encoding and sample-word layout.
package ofdm_preamble_inserter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_PRE   = 2'd1;
   localparam state_t ST_PAY   = 2'd2;
   localparam state_t ST_DRAIN = 2'd3;

   // Sample word is {last, pre, q, i}; i occupies the low DW bits.
   function automatic int smp_w(input int dw);
      return 2 * dw + 2;
   endfunction

endpackage

// File: rtl/ofdm_skid_buf.sv
// Two-entry valid/ready register buffer; the head entry drives the output directly.
module ofdm_skid_buf #(
   parameter int W = 34
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic [W-1:0] ent0, ent1;
   logic         push, pop;

   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign out_data  = ent0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0 <= '0;
         ent1 <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) ent0 <= in_data;
               else             ent1 <= in_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) ent0 <= in_data;
               else begin
                  ent0 <= ent1;
                  ent1 <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ofdm_preamble_inserter.sv
// Frame sequencer: streams PRE_REPS copies of the ROM preamble, then payload up to s_last.
module ofdm_preamble_inserter
   import ofdm_preamble_inserter_pkg::*;
#(
   parameter int DW       = 16,
   parameter int AW       = 8,
   parameter int PRE_LEN  = 160,
   parameter int PRE_REPS = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   output logic          busy,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_i,
   input  logic [DW-1:0] rom_q,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_i,
   input  logic [DW-1:0] s_q,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_i,
   output logic [DW-1:0] m_q,
   output logic          m_pre,
   output logic          m_last
);

   localparam int              SW        = smp_w(DW);
   localparam int              STAGES    = 1;
   localparam logic [AW-1:0]   LAST_ADDR = AW'(PRE_LEN - 1);
   localparam logic [3:0]      LAST_REP  = 4'(PRE_REPS - 1);

   state_t          state;
   logic [AW-1:0]   addr_cnt;
   logic [3:0]      rep_cnt;
   logic [STAGES:0] vld_pipe;
   logic [1:0]      occ;
   logic [2:0]      load;
   logic            issue, s_hs, push, skid_rdy;
   logic [SW-1:0]   push_word, m_word;

   // A read lands two edges after issue, so both pipe stages count against free slots.
   assign load      = {1'b0, occ} + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
   assign issue     = (state == ST_PRE) && (load < 3'd2);
   assign s_ready   = (state == ST_PAY) && skid_rdy && (vld_pipe == '0);
   assign s_hs      = s_valid && s_ready;
   assign push      = vld_pipe[STAGES] || s_hs;
   assign push_word = vld_pipe[STAGES] ? {1'b0, 1'b1, rom_q, rom_i}
                                       : {s_last, 1'b0, s_q, s_i};
   assign busy      = (state != ST_IDLE);

   assign m_i    = m_word[DW-1:0];
   assign m_q    = m_word[2*DW-1:DW];
   assign m_pre  = m_word[2*DW];
   assign m_last = m_word[2*DW+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         addr_cnt <= '0;
         rep_cnt  <= '0;
         rom_addr <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], issue};
         case (state)
            ST_IDLE: if (frame_start) begin
               state    <= ST_PRE;
               addr_cnt <= '0;
               rep_cnt  <= '0;
            end
            ST_PRE: if (issue) begin
               rom_addr <= addr_cnt;
               if (addr_cnt == LAST_ADDR) begin
                  addr_cnt <= '0;
                  rep_cnt  <= rep_cnt + 4'd1;
                  if (rep_cnt == LAST_REP) state <= ST_PAY;
               end else begin
                  addr_cnt <= addr_cnt + 1'b1;
               end
            end
            ST_PAY: if (s_hs && s_last) state <= ST_DRAIN;
            // Leave on the final pop so busy drops right after the last handshake.
            ST_DRAIN: if (occ == 2'd0 || (occ == 2'd1 && m_valid && m_ready)) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   ofdm_skid_buf #(.W(SW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (push),
      .in_ready  (skid_rdy),
      .in_data   (push_word),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_word),
      .occ       (occ)
   );

endmodule
